// File: rtl/flash_word_reader.sv
// Word reader for the 8-bit parallel NOR flash: two timed byte reads per toggle request.
// Build option FLASH_BYTE_SWAP_EN puts the even-address byte in ofl_data[7:0] instead of [15:8].
module flash_word_reader #(
  parameter int ACCESS_CYCLES = 6,
  parameter int RST_CYCLES    = 32
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic [22:0] ifl_addr,
  input  logic        ifl_req,
  output logic        ofl_ack,
  output logic [15:0] ofl_data,
  output logic [22:0] oflash_addr,
  input  logic [7:0]  iflash_dq,
  output logic        oflash_ce_n,
  output logic        oflash_oe_n,
  output logic        oflash_we_n,
  output logic        oflash_rst_n,
  output logic        oflash_wp_n
);

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_IDLE     = 2'd1,
    ST_READ_HI  = 2'd2,
    ST_READ_LO  = 2'd3
  } state_t;

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);
  localparam logic [7:0] ACC_LOAD = 8'(ACCESS_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_hi;
  logic        r_ack;
  logic [15:0] r_data;
  logic [22:0] r_addr;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_rst_n;

  state_t      w_state_next;
  logic [7:0]  w_cnt_next;
  logic [7:0]  w_hi_next;
  logic        w_ack_next;
  logic [15:0] w_data_next;
  logic [22:0] w_addr_next;
  logic        w_ce_n_next;
  logic        w_oe_n_next;
  logic        w_rst_n_next;
  logic [15:0] w_word;

`ifdef FLASH_BYTE_SWAP_EN
  assign w_word = {iflash_dq, r_hi};
`else
  assign w_word = {r_hi, iflash_dq};
`endif

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= ST_RST_HOLD;
      r_cnt   <= RST_LOAD;
      r_hi    <= 8'h00;
      r_ack   <= 1'b0;
      r_data  <= 16'h0000;
      r_addr  <= 23'h000000;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_rst_n <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi    <= w_hi_next;
      r_ack   <= w_ack_next;
      r_data  <= w_data_next;
      r_addr  <= w_addr_next;
      r_ce_n  <= w_ce_n_next;
      r_oe_n  <= w_oe_n_next;
      r_rst_n <= w_rst_n_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_next    = r_hi;
    w_ack_next   = r_ack;
    w_data_next  = r_data;
    w_addr_next  = r_addr;
    w_ce_n_next  = r_ce_n;
    w_oe_n_next  = r_oe_n;
    w_rst_n_next = r_rst_n;

    case (r_state)
      ST_RST_HOLD: begin
        w_rst_n_next = 1'b0;
        w_ce_n_next  = 1'b1;
        w_oe_n_next  = 1'b1;
        if (r_cnt == 8'd0) begin
          w_rst_n_next = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      ST_IDLE: begin
        w_ce_n_next = 1'b1;
        w_oe_n_next = 1'b1;
        if (ifl_req != r_ack) begin
          // Bit 0 is forced low; the word always starts at the even byte.
          w_addr_next  = {ifl_addr[22:1], 1'b0};
          w_ce_n_next  = 1'b0;
          w_oe_n_next  = 1'b0;
          w_cnt_next   = ACC_LOAD;
          w_state_next = ST_READ_HI;
        end
      end
      ST_READ_HI: begin
        if (r_cnt == 8'd0) begin
          w_hi_next    = iflash_dq;
          w_addr_next  = {r_addr[22:1], 1'b1};
          w_cnt_next   = ACC_LOAD;
          w_state_next = ST_READ_LO;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      ST_READ_LO: begin
        if (r_cnt == 8'd0) begin
          w_data_next  = w_word;
          w_ack_next   = ~r_ack;
          w_ce_n_next  = 1'b1;
          w_oe_n_next  = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_next = ST_RST_HOLD;
        w_cnt_next   = RST_LOAD;
        w_rst_n_next = 1'b0;
      end
    endcase
  end

  assign ofl_ack      = r_ack;
  assign ofl_data     = r_data;
  assign oflash_addr  = r_addr;
  assign oflash_ce_n  = r_ce_n;
  assign oflash_oe_n  = r_oe_n;
  assign oflash_rst_n = r_rst_n;
  assign oflash_we_n  = 1'b1;
  assign oflash_wp_n  = 1'b0;

endmodule

// File: tb/tb_flash_word_reader.sv
// Self-checking bench for flash_word_reader: table vectors, reset corner cases, random reads
// against a byte-array flash model that only returns valid data after the full access time.
module tb_flash_word_reader;
  localparam int ACC  = 6;
  localparam int RSTC = 32;

  logic        iclk = 1'b0;
  logic        ireset;
  logic [22:0] ifl_addr;
  logic        ifl_req;
  logic        ofl_ack;
  logic [15:0] ofl_data;
  logic [22:0] oflash_addr;
  logic [7:0]  iflash_dq;
  logic        oflash_ce_n, oflash_oe_n, oflash_we_n, oflash_rst_n, oflash_wp_n;

  int n_tests = 0;
  int n_fail  = 0;

  flash_word_reader #(.ACCESS_CYCLES(ACC), .RST_CYCLES(RSTC)) dut (
    .iclk(iclk), .ireset(ireset), .ifl_addr(ifl_addr), .ifl_req(ifl_req),
    .ofl_ack(ofl_ack), .ofl_data(ofl_data), .oflash_addr(oflash_addr),
    .iflash_dq(iflash_dq), .oflash_ce_n(oflash_ce_n), .oflash_oe_n(oflash_oe_n),
    .oflash_we_n(oflash_we_n), .oflash_rst_n(oflash_rst_n), .oflash_wp_n(oflash_wp_n)
  );

  always #5 iclk = ~iclk;

  // Flash contents: a few fixed bytes, everything else a hash of the address.
  logic [7:0] mem_ovr [logic [22:0]];

  function automatic logic [7:0] mem_byte(input logic [22:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return a[7:0] ^ {a[14:8], a[22]} ^ a[21:14] ^ 8'h3C;
  endfunction

  function automatic logic [15:0] model_word(input logic [22:0] a);
    return {mem_byte({a[22:1], 1'b0}), mem_byte({a[22:1], 1'b1})};
  endfunction

  function automatic logic [15:0] order(input logic [15:0] be);
`ifdef FLASH_BYTE_SWAP_EN
    return {be[7:0], be[15:8]};
`else
    return be;
`endif
  endfunction

  // Data is driven only once the address has been held ACC cycles with CE/OE low.
  logic [22:0] prev_addr = 23'h0;
  int          age = 0;
  initial iflash_dq = 8'hEE;
  always @(negedge iclk) begin
    if (oflash_addr !== prev_addr) age = 0;
    else if (age < 1000) age = age + 1;
    prev_addr = oflash_addr;
    if (!oflash_ce_n && !oflash_oe_n && age >= ACC - 1) iflash_dq <= mem_byte(oflash_addr);
    else iflash_dq <= 8'hEE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller has just toggled ifl_req at a negedge; the next posedge is the detecting edge N.
  task automatic monitor_read(input logic [22:0] a, input logic [15:0] exp_be, input string name);
    logic [15:0] exp_w;
    logic        req_now, ack0;
    exp_w   = order(exp_be);
    req_now = ifl_req;
    ack0    = ofl_ack;
    for (int k = 0; k < 2 * ACC; k++) begin
      @(negedge iclk);
      check({name, ":addr"}, 32'(oflash_addr), 32'({a[22:1], (k >= ACC) ? 1'b1 : 1'b0}));
      check({name, ":busy_ce_oe"}, {30'd0, oflash_ce_n, oflash_oe_n}, 32'd0);
      check({name, ":ack_early"}, 32'(ofl_ack), 32'(ack0));
    end
    @(negedge iclk);
    check({name, ":ack"}, 32'(ofl_ack), 32'(req_now));
    check({name, ":data"}, 32'(ofl_data), 32'(exp_w));
    check({name, ":ce_oe_after"}, {30'd0, oflash_ce_n, oflash_oe_n}, 32'd3);
    $display("[TB] read %s addr=%06h data=%04h ack=%0d", name, a, ofl_data, ofl_ack);
  endtask

  task automatic do_read(input logic [22:0] a, input int gap, input logic [15:0] exp_be,
                         input string name);
    repeat (gap) @(negedge iclk);
    ifl_addr = a;
    ifl_req  = ~ifl_req;
    monitor_read(a, exp_be, name);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, ":ack"}, 32'(ofl_ack), 32'd0);
    check({name, ":data"}, 32'(ofl_data), 32'd0);
    check({name, ":addr"}, 32'(oflash_addr), 32'd0);
    check({name, ":ce_oe"}, {30'd0, oflash_ce_n, oflash_oe_n}, 32'd3);
    check({name, ":rst_n"}, 32'(oflash_rst_n), 32'd0);
    check({name, ":we_wp"}, {30'd0, oflash_we_n, oflash_wp_n}, 32'd2);
  endtask

  typedef struct {
    logic [22:0] addr;
    int          gap;
    logic [15:0] exp_be;
    string       name;
  } vec_t;

  vec_t tbl [6];

  initial begin
    mem_ovr[23'h000010] = 8'h12;
    mem_ovr[23'h000011] = 8'h34;
    mem_ovr[23'h7FFFFE] = 8'hAB;
    mem_ovr[23'h7FFFFF] = 8'hCD;
    mem_ovr[23'h400000] = 8'h5A;
    mem_ovr[23'h400001] = 8'hC3;

    tbl[0] = '{23'h000010, 2, 16'h1234, "single"};
    tbl[1] = '{23'h000011, 1, 16'h1234, "odd_addr"};
    tbl[2] = '{23'h7FFFFE, 0, 16'hABCD, "b2b_top"};
    tbl[3] = '{23'h7FFFFF, 0, 16'hABCD, "b2b_top_odd"};
    tbl[4] = '{23'h400001, 3, 16'h5AC3, "mid"};
    tbl[5] = '{23'h000010, 0, 16'h1234, "b2b_low"};

    ireset   = 1'b1;
    ifl_req  = 1'b0;
    ifl_addr = 23'h0;

    // Reset for 3 cycles, then hold sequence with a request pending during hold.
    repeat (3) begin
      @(negedge iclk);
      check_reset_vals("reset");
    end
    ireset = 1'b0;
    for (int i = 1; i <= RSTC; i++) begin
      @(negedge iclk);
      check("hold:we_wp", {30'd0, oflash_we_n, oflash_wp_n}, 32'd2);
      check("hold:ack", 32'(ofl_ack), 32'd0);
      check("hold:ce", 32'(oflash_ce_n), 32'd1);
      check("hold:rst_n", 32'(oflash_rst_n), (i == RSTC) ? 32'd1 : 32'd0);
      if (i == 5) begin
        ifl_addr = 23'h000010;
        ifl_req  = 1'b1;
      end
    end
    monitor_read(23'h000010, 16'h1234, "req_in_hold");

    for (int t = 0; t < 6; t++)
      do_read(tbl[t].addr, tbl[t].gap, tbl[t].exp_be, tbl[t].name);

    // Reset asserted at edge N+8 of a read: aborted with no ack toggle.
    ifl_addr = 23'h7FFFFE;
    ifl_req  = ~ifl_req;
    repeat (8) @(negedge iclk);
    check("midrd:busy", 32'(oflash_ce_n), 32'd0);
    ireset = 1'b1;
    @(negedge iclk);
    ireset  = 1'b0;
    ifl_req = 1'b0;
    check_reset_vals("midrd");
    for (int i = 1; i <= RSTC; i++) begin
      @(negedge iclk);
      check("midrd:rst_n", 32'(oflash_rst_n), (i == RSTC) ? 32'd1 : 32'd0);
      check("midrd:ack", 32'(ofl_ack), 32'd0);
    end
    do_read(23'h000011, 1, 16'h1234, "after_reset");

    // Random reads against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [22:0] a;
      a = 23'($urandom);
      do_read(a, $urandom_range(0, 3), model_word(a), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
